xaui_tx_pcs: RTL

//  Transmit PCS for the XAUI core. Converts 64-bit XGMII TX (two columns per usrclk) into 8b/10b-ready

---
 rtl/xaui_tx_pcs.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/xaui_tx_pcs.sv
// xaui_tx_pcs - XAUI transmit PCS.
//
// Maps 64-bit XGMII TX data (two columns per usrclk) onto four MGT lanes as
// 8b/10b-ready bytes plus charisk flags. Idle columns are replaced by the
// ||A||/||K||/||R|| randomised idle sequence. Control codes are mapped, and
// illegal codes are forced to /E/.
//
// Ports
//   usrclk         clock
//   reset          synchronous, active-high reset
//   xgmii_txd      [31:0] column0, [63:32] column1; lane n = byte n of a column
//   xgmii_txc      bit c*4+n = control flag for column c, lane n
//   mgt_txdata     lane n = [16n+15:16n]; low byte column0, high byte column1
//   mgt_txcharisk  bit 2n = lane n column0, bit 2n+1 = lane n column1
//   tx_code_err    pulse, aligned with mgt_txdata, when any byte was forced to /E/
//   testpat_en     test-pattern enable (only with XAUI_TX_TESTPAT_EN)
//   testpat_sel    0=high-freq, 1=low-freq, 2=mixed, 3=normal path
//
// Build option: define XAUI_TX_TESTPAT_EN to build the test-pattern override.
// Without it, testpat_en and testpat_sel are ignored.

module xaui_tx_pcs #(
    parameter int         A_MIN       = 16,
    parameter int         A_RAND_BITS = 4,
    parameter logic [6:0] LFSR_SEED   = 7'h7F
) (
    input  logic        usrclk,
    input  logic        reset,
    input  logic [63:0] xgmii_txd,
    input  logic [7:0]  xgmii_txc,
    output logic [63:0] mgt_txdata,
    output logic [7:0]  mgt_txcharisk,
    output logic        tx_code_err,
    input  logic        testpat_en,
    input  logic [1:0]  testpat_sel
);

    localparam logic [7:0] C_IDLE = 8'h07;
    localparam logic [7:0] C_A    = 8'h7C;
    localparam logic [7:0] C_R    = 8'h1C;
    localparam logic [7:0] C_K    = 8'hBC;
    localparam logic [7:0] C_S    = 8'hFB;
    localparam logic [7:0] C_T    = 8'hFD;
    localparam logic [7:0] C_E    = 8'hFE;
    localparam logic [7:0] C_Q    = 8'h9C;
    localparam logic [4:0] A_MIN5 = 5'(A_MIN);

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        err;
        logic [4:0]  a_cnt;
        logic [6:0]  lfsr;
    } col_res_t;

    logic [6:0]  lfsr;
    logic [4:0]  a_cnt;
    col_res_t    col0_p0;
    col_res_t    col1_p0;
    logic [63:0] txdata_p0;
    logic [7:0]  charisk_p0;

    // Encode one XGMII column against the given idle state. Returns the
    // lane bytes, charisk flags, error flag and the updated idle state.
    function automatic col_res_t encode_col(input logic [31:0] d, input logic [3:0] c,
                                            input logic [4:0] cnt, input logic [6:0] lf);
        col_res_t   r;
        logic       is_idle;
        logic       found;
        int         kpos;
        logic [7:0] b;
        logic [4:0] rnd;
        r       = '0;
        r.a_cnt = cnt;
        r.lfsr  = lf;
        rnd     = '0;
        rnd[A_RAND_BITS-1:0] = lf[A_RAND_BITS-1:0];
        is_idle = (c == 4'hF);
        found   = 1'b0;
        kpos    = 0;
        for (int i = 0; i < 4; i++) begin
            if (d[8*i +: 8] != C_IDLE) is_idle = 1'b0;
        end
        // Scan downward so the lowest control lane wins.
        for (int i = 3; i >= 0; i--) begin
            if (c[i]) begin
                found = 1'b1;
                kpos  = i;
            end
        end

        if (is_idle) begin
            r.k = 4'hF;
            if (cnt == 5'd0) begin
                r.d     = {4{C_A}};
                r.a_cnt = A_MIN5 + rnd;
            end else begin
                r.d     = lf[0] ? {4{C_R}} : {4{C_K}};
                r.a_cnt = cnt - 5'd1;
            end
            r.lfsr = {lf[5:0], lf[6] ^ lf[5]};
        end else if (found && d[8*kpos +: 8] == C_T) begin
            // Lanes after /T/ must be idle; they become K, anything else /E/.
            for (int i = 0; i < 4; i++) begin
                b = d[8*i +: 8];
                if (i < kpos) begin
                    r.d[8*i +: 8] = b;
                end else if (i == kpos) begin
                    r.d[8*i +: 8] = C_T;
                    r.k[i]        = 1'b1;
                end else if (c[i] && b == C_IDLE) begin
                    r.d[8*i +: 8] = C_K;
                    r.k[i]        = 1'b1;
                end else begin
                    r.d[8*i +: 8] = C_E;
                    r.k[i]        = 1'b1;
                    r.err         = 1'b1;
                end
            end
        end else if (c == 4'b0001 && d[7:0] == C_Q) begin
            r.d = d;
            r.k = 4'b0001;
        end else begin
            for (int i = 0; i < 4; i++) begin
                b = d[8*i +: 8];
                if (!c[i]) begin
                    r.d[8*i +: 8] = b;
                end else if (b == C_S || b == C_T || b == C_E || b == C_Q) begin
                    r.d[8*i +: 8] = b;
                    r.k[i]        = 1'b1;
                end else begin
                    r.d[8*i +: 8] = C_E;
                    r.k[i]        = 1'b1;
                    r.err         = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Stage p0: combinational encode, column1 chained on column0's state.
    always_comb begin
        txdata_p0  = '0;
        charisk_p0 = '0;
        col0_p0    = encode_col(xgmii_txd[31:0],  xgmii_txc[3:0], a_cnt, lfsr);
        col1_p0    = encode_col(xgmii_txd[63:32], xgmii_txc[7:4], col0_p0.a_cnt, col0_p0.lfsr);
        for (int n = 0; n < 4; n++) begin
            txdata_p0[16*n +: 8]     = col0_p0.d[8*n +: 8];
            txdata_p0[16*n+8 +: 8]   = col1_p0.d[8*n +: 8];
            charisk_p0[2*n]          = col0_p0.k[n];
            charisk_p0[2*n+1]        = col1_p0.k[n];
        end
    end

`ifdef XAUI_TX_TESTPAT_EN
    logic       tp_active;
    logic [7:0] tp_byte;
    logic       tp_k;

    assign tp_active = testpat_en && (testpat_sel != 2'd3);

    always_comb begin
        tp_byte = C_K;
        tp_k    = 1'b1;
        case (testpat_sel)
            2'd0: begin
                tp_byte = 8'hB5;
                tp_k    = 1'b0;
            end
            2'd1: tp_byte = 8'hFC;
            default: tp_byte = C_K;
        endcase
    end
`else
    logic unused_testpat;
    assign unused_testpat = ^{testpat_en, testpat_sel};
`endif

    // Stage p1: registered outputs and idle-sequence state.
    always_ff @(posedge usrclk) begin
        if (reset) begin
            mgt_txdata    <= {8{C_K}};
            mgt_txcharisk <= 8'hFF;
            tx_code_err   <= 1'b0;
            lfsr          <= LFSR_SEED;
            a_cnt         <= 5'd0;
        end else begin
`ifdef XAUI_TX_TESTPAT_EN
            if (tp_active) begin
                // Idle state is frozen while the pattern is on the wire.
                mgt_txdata    <= {8{tp_byte}};
                mgt_txcharisk <= {8{tp_k}};
                tx_code_err   <= 1'b0;
            end else
`endif
            begin
                mgt_txdata    <= txdata_p0;
                mgt_txcharisk <= charisk_p0;
                tx_code_err   <= col0_p0.err | col1_p0.err;
                lfsr          <= col1_p0.lfsr;
                a_cnt         <= col1_p0.a_cnt;
            end
        end
    end

endmodule
